// File: rtl/cp0_intc.sv
// Coprocessor 0: Count/Compare timers, Status/Cause/EPC, precise exceptions and ERET; optional CP0_COUNT_DIV2_EN halves the Count rate.
// Latency: register reads are combinational; writes, exception commits and IP sampling land at the next clk edge.
// Backpressure: no handshake; stall blocks exception/ERET commits while MTC0 and timers keep running.
module cp0_intc #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int N_HW_INT   = 6,
    parameter int N_TIMERS   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reg_we,
    input  logic [4:0]            reg_write_addr,
    input  logic [2:0]            reg_write_sel,
    input  logic [DATA_WIDTH-1:0] reg_write,
    input  logic [4:0]            reg_read_addr,
    input  logic [2:0]            reg_read_sel,
    output logic [DATA_WIDTH-1:0] reg_read,
    input  logic [N_HW_INT-1:0]   hardware_int,
    input  logic                  stall,
    input  logic                  exc_valid,
    input  logic [4:0]            exc_code,
    input  logic [ADDR_WIDTH-1:0] exc_pc,
    input  logic                  exc_bd,
    input  logic                  eret,
    output logic                  int_req,
    output logic [ADDR_WIDTH-1:0] exc_vector,
    output logic [ADDR_WIDTH-1:0] epc,
    output logic [31:0]           status,
    output logic [31:0]           cause,
    output logic [N_TIMERS-1:0]   timer_int
);

    localparam logic [4:0] R_COUNT   = 5'd9;
    localparam logic [4:0] R_COMPARE = 5'd11;
    localparam logic [4:0] R_STATUS  = 5'd12;
    localparam logic [4:0] R_CAUSE   = 5'd13;
    localparam logic [4:0] R_EPC     = 5'd14;
    localparam logic [4:0] R_PRID    = 5'd15;
    localparam logic [4:0] R_CONFIG  = 5'd16;

    logic [DATA_WIDTH-1:0] count_q;
    logic [DATA_WIDTH-1:0] compare_q [N_TIMERS];
    logic [N_TIMERS-1:0]   armed_q;
    logic [N_TIMERS-1:0]   timer_int_q;
    logic [7:0]            im_q;
    logic                  bev_q, exl_q, ie_q;
    logic [1:0]            ip_sw_q;
    logic [N_HW_INT-1:0]   hw_q;
    logic                  bd_q;
    logic [4:0]            exc_code_q;
    logic [ADDR_WIDTH-1:0] epc_q;

    logic       wr_count, wr_compare, wr_status, wr_cause, wr_epc;
    logic       exc_fire, eret_fire, tick;
    logic [5:0] hw_ext;
    logic [7:0] ip;

    assign wr_count   = reg_we && (reg_write_addr == R_COUNT);
    assign wr_compare = reg_we && (reg_write_addr == R_COMPARE);
    assign wr_status  = reg_we && (reg_write_addr == R_STATUS);
    assign wr_cause   = reg_we && (reg_write_addr == R_CAUSE);
    assign wr_epc     = reg_we && (reg_write_addr == R_EPC);
    assign exc_fire   = exc_valid && !stall;
    assign eret_fire  = eret && !stall;

`ifdef CP0_COUNT_DIV2_EN
    // Count advances (and compares are evaluated) only on the odd prescaler phase.
    logic phase_q;
    assign tick = phase_q;

    always_ff @(posedge clk) begin
        if (rst || wr_count)
            phase_q <= 1'b0;
        else
            phase_q <= ~phase_q;
    end
`else
    assign tick = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            count_q <= '0;
        else if (wr_count)
            count_q <= reg_write;
        else if (tick)
            count_q <= count_q + DATA_WIDTH'(1);
    end

    // A write to a channel clears its flag even if that edge is also a match.
    always_ff @(posedge clk) begin
        if (rst) begin
            armed_q     <= '0;
            timer_int_q <= '0;
            for (int k = 0; k < N_TIMERS; k++)
                compare_q[k] <= '0;
        end else begin
            for (int k = 0; k < N_TIMERS; k++) begin
                if (wr_compare && (reg_write_sel == 3'(k))) begin
                    compare_q[k]   <= reg_write;
                    armed_q[k]     <= 1'b1;
                    timer_int_q[k] <= 1'b0;
                end else if (armed_q[k] && tick && (count_q == compare_q[k])) begin
                    timer_int_q[k] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            im_q  <= '0;
            bev_q <= 1'b1;
            exl_q <= 1'b0;
            ie_q  <= 1'b0;
        end else begin
            if (wr_status) begin
                im_q  <= reg_write[15:8];
                bev_q <= reg_write[22];
                exl_q <= reg_write[1];
                ie_q  <= reg_write[0];
            end
            if (exc_fire)
                exl_q <= 1'b1;
            else if (eret_fire)
                exl_q <= 1'b0;
        end
    end

    // A nested exception (EXL already set) keeps the original EPC/BD context.
    always_ff @(posedge clk) begin
        if (rst) begin
            ip_sw_q    <= '0;
            hw_q       <= '0;
            bd_q       <= 1'b0;
            exc_code_q <= '0;
            epc_q      <= '0;
        end else begin
            hw_q <= hardware_int;
            if (wr_cause)
                ip_sw_q <= reg_write[9:8];
            if (exc_fire)
                exc_code_q <= exc_code;
            if (exc_fire && !exl_q) begin
                bd_q  <= exc_bd;
                epc_q <= exc_bd ? (exc_pc - ADDR_WIDTH'(4)) : exc_pc;
            end else if (wr_epc) begin
                epc_q <= ADDR_WIDTH'(reg_write);
            end
        end
    end

    assign hw_ext = 6'(hw_q);
    assign ip     = {(|timer_int_q) | hw_ext[5], hw_ext[4:0], ip_sw_q};

    assign status     = {4'b0001, 5'b0, bev_q, 6'b0, im_q, 6'b0, exl_q, ie_q};
    assign cause      = {bd_q, 15'b0, ip, 1'b0, exc_code_q, 2'b0};
    assign epc        = epc_q;
    assign timer_int  = timer_int_q;
    assign int_req    = ie_q && !exl_q && (|(ip & im_q));
    assign exc_vector = bev_q ? ADDR_WIDTH'(32'hBFC0_0380) : ADDR_WIDTH'(32'h8000_0180);

    always_comb begin
        reg_read = '0;
        case (reg_read_addr)
            R_COUNT:   reg_read = count_q;
            R_COMPARE: begin
                for (int k = 0; k < N_TIMERS; k++)
                    if (reg_read_sel == 3'(k))
                        reg_read = compare_q[k];
            end
            R_STATUS:  reg_read = DATA_WIDTH'(status);
            R_CAUSE:   reg_read = DATA_WIDTH'(cause);
            R_EPC:     reg_read = DATA_WIDTH'(epc_q);
            R_PRID:    reg_read = '0;
            R_CONFIG:  reg_read = DATA_WIDTH'(32'h0000_8000);
            default:   reg_read = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_intc.sv
// Scoreboarded bench for cp0_intc: expectations queued at stimulus time, popped when outputs are sampled.
module tb_cp0_intc;

`ifdef CP0_COUNT_DIV2_EN
    localparam int DIV = 2;
`else
    localparam int DIV = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_we;
    logic [4:0]  reg_write_addr;
    logic [2:0]  reg_write_sel;
    logic [31:0] reg_write;
    logic [4:0]  reg_read_addr;
    logic [2:0]  reg_read_sel;
    logic [31:0] reg_read;
    logic [5:0]  hardware_int;
    logic        stall;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_bd;
    logic        eret;
    logic        int_req;
    logic [31:0] exc_vector;
    logic [31:0] epc;
    logic [31:0] status;
    logic [31:0] cause;
    logic [0:0]  timer_int;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] v, e;
    bit          found;

    cp0_intc dut (
        .clk(clk), .rst(rst),
        .reg_we(reg_we), .reg_write_addr(reg_write_addr), .reg_write_sel(reg_write_sel),
        .reg_write(reg_write), .reg_read_addr(reg_read_addr), .reg_read_sel(reg_read_sel),
        .reg_read(reg_read), .hardware_int(hardware_int), .stall(stall),
        .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
        .eret(eret), .int_req(int_req), .exc_vector(exc_vector), .epc(epc),
        .status(status), .cause(cause), .timer_int(timer_int)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [2:0] s, input logic [31:0] d);
        reg_we = 1'b1; reg_write_addr = a; reg_write_sel = s; reg_write = d;
        step(1);
        reg_we = 1'b0;
    endtask

    task automatic read_reg(input logic [4:0] a, input logic [2:0] s, output logic [31:0] d);
        reg_read_addr = a; reg_read_sel = s;
        #1;
        d = reg_read;
    endtask

    task automatic pulse_exc(input logic [4:0] code, input logic [31:0] pc, input logic bd, input logic stl);
        exc_valid = 1'b1; exc_code = code; exc_pc = pc; exc_bd = bd; stall = stl;
        step(1);
        exc_valid = 1'b0; stall = 1'b0;
    endtask

    task test_reset;
        // Pending exception and MTC0 during reset must be discarded.
        rst = 1'b1; exc_valid = 1'b1; exc_pc = 32'h500; exc_code = 5'd12; exc_bd = 1'b0;
        reg_we = 1'b1; reg_write_addr = 5'd12; reg_write = 32'h0000_FF03;
        exp_q.push_back(32'h1040_0000); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        exp_q.push_back(32'hBFC0_0380); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        exp_q.push_back(32'h0000_8000); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        step(3);
        rst = 1'b0; exc_valid = 1'b0; reg_we = 1'b0;
        read_reg(5'd12, 3'd0, v);
        e = exp_q.pop_front(); n_checks++;
        if (v !== e) begin n_fail++; $display("FAIL reset_status: got %h expected %h", v, e); end
        read_reg(5'd13, 3'd0, v);
        e = exp_q.pop_front(); n_checks++;
        if (v !== e) begin n_fail++; $display("FAIL reset_cause: got %h expected %h", v, e); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(int_req) !== e) begin n_fail++; $display("FAIL reset_int_req: got %h expected %h", int_req, e); end
        e = exp_q.pop_front(); n_checks++;
        if (exc_vector !== e) begin n_fail++; $display("FAIL reset_vector: got %h expected %h", exc_vector, e); end
        e = exp_q.pop_front(); n_checks++;
        if (epc !== e) begin n_fail++; $display("FAIL reset_epc: got %h expected %h", epc, e); end
        read_reg(5'd9, 3'd0, v);
        e = exp_q.pop_front(); n_checks++;
        if (v !== e) begin n_fail++; $display("FAIL reset_count: got %h expected %h", v, e); end
        read_reg(5'd16, 3'd0, v);
        e = exp_q.pop_front(); n_checks++;
        if (v !== e) begin n_fail++; $display("FAIL config: got %h expected %h", v, e); end
        read_reg(5'd11, 3'd1, v);
        e = exp_q.pop_front(); n_checks++;
        if (v !== e) begin n_fail++; $display("FAIL compare_sel1: got %h expected %h", v, e); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(timer_int) !== e) begin n_fail++; $display("FAIL reset_timer_int: got %h expected %h", timer_int, e); end
    endtask

    task test_timer;
        mtc0(5'd9, 3'd0, 32'd10);
        mtc0(5'd11, 3'd0, 32'd20);
        exp_q.push_back(32'd21);
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            read_reg(5'd9, 3'd0, v);
            if (timer_int[0]) found = 1'b1;
            else step(1);
        end
        e = exp_q.pop_front(); n_checks++;
        if (!found) begin n_fail++; $display("FAIL timer_wait: timer_int never rose, count %h expected %h", v, e); end
        else if (v !== e) begin n_fail++; $display("FAIL timer_match_count: got %h expected %h", v, e); end
        exp_q.push_back(32'h1); exp_q.push_back(32'h8000_0180); exp_q.push_back(32'h1000_8001);
        mtc0(5'd12, 3'd0, 32'h0000_8001);
        e = exp_q.pop_front(); n_checks++;
        if (32'(int_req) !== e) begin n_fail++; $display("FAIL timer_int_req: got %h expected %h", int_req, e); end
        e = exp_q.pop_front(); n_checks++;
        if (exc_vector !== e) begin n_fail++; $display("FAIL vector_bev0: got %h expected %h", exc_vector, e); end
        e = exp_q.pop_front(); n_checks++;
        if (status !== e) begin n_fail++; $display("FAIL status_write: got %h expected %h", status, e); end
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        mtc0(5'd11, 3'd0, 32'hFFFF_0000);
        e = exp_q.pop_front(); n_checks++;
        if (32'(timer_int) !== e) begin n_fail++; $display("FAIL timer_clear: got %h expected %h", timer_int, e); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(int_req) !== e) begin n_fail++; $display("FAIL timer_clear_int_req: got %h expected %h", int_req, e); end
    endtask

    task test_clear_wins;
        mtc0(5'd11, 3'd0, 32'd40);
        mtc0(5'd9, 3'd0, 32'd39);
        step(2 * DIV - 1);
        exp_q.push_back(32'd40); exp_q.push_back(32'h0);
        read_reg(5'd9, 3'd0, v);
        e = exp_q.pop_front(); n_checks++;
        if (v !== e) begin n_fail++; $display("FAIL clear_wins_count: got %h expected %h", v, e); end
        mtc0(5'd11, 3'd0, 32'hFFFF_0000);
        e = exp_q.pop_front(); n_checks++;
        if (32'(timer_int) !== e) begin n_fail++; $display("FAIL clear_wins: got %h expected %h", timer_int, e); end
    endtask

    task test_exception;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        pulse_exc(5'd12, 32'h0000_0104, 1'b1, 1'b1);
        e = exp_q.pop_front(); n_checks++;
        if (32'(status[1]) !== e) begin n_fail++; $display("FAIL stall_exl: got %h expected %h", status[1], e); end
        e = exp_q.pop_front(); n_checks++;
        if (epc !== e) begin n_fail++; $display("FAIL stall_epc: got %h expected %h", epc, e); end
        exp_q.push_back(32'h0000_0100); exp_q.push_back(32'h8000_0030);
        exp_q.push_back(32'h1); exp_q.push_back(32'h0);
        pulse_exc(5'd12, 32'h0000_0104, 1'b1, 1'b0);
        read_reg(5'd14, 3'd0, v);
        e = exp_q.pop_front(); n_checks++;
        if (v !== e) begin n_fail++; $display("FAIL exc_epc_bd: got %h expected %h", v, e); end
        e = exp_q.pop_front(); n_checks++;
        if (cause !== e) begin n_fail++; $display("FAIL exc_cause: got %h expected %h", cause, e); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(status[1]) !== e) begin n_fail++; $display("FAIL exc_exl: got %h expected %h", status[1], e); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(int_req) !== e) begin n_fail++; $display("FAIL exc_int_masked: got %h expected %h", int_req, e); end
        exp_q.push_back(32'h0000_0100); exp_q.push_back(32'h8000_0020);
        pulse_exc(5'd8, 32'h0000_0200, 1'b0, 1'b0);
        e = exp_q.pop_front(); n_checks++;
        if (epc !== e) begin n_fail++; $display("FAIL nested_epc: got %h expected %h", epc, e); end
        e = exp_q.pop_front(); n_checks++;
        if (cause !== e) begin n_fail++; $display("FAIL nested_cause: got %h expected %h", cause, e); end
        exp_q.push_back(32'h0);
        eret = 1'b1; step(1); eret = 1'b0;
        e = exp_q.pop_front(); n_checks++;
        if (32'(status[1]) !== e) begin n_fail++; $display("FAIL eret_exl: got %h expected %h", status[1], e); end
    endtask

    task test_simultaneous;
        exp_q.push_back(32'h1000_FF03); exp_q.push_back(32'h0000_0300); exp_q.push_back(32'h0000_0034);
        reg_we = 1'b1; reg_write_addr = 5'd12; reg_write = 32'h0000_FF01;
        eret = 1'b1;
        pulse_exc(5'd13, 32'h0000_0300, 1'b0, 1'b0);
        reg_we = 1'b0; eret = 1'b0;
        e = exp_q.pop_front(); n_checks++;
        if (status !== e) begin n_fail++; $display("FAIL simul_status: got %h expected %h", status, e); end
        e = exp_q.pop_front(); n_checks++;
        if (epc !== e) begin n_fail++; $display("FAIL simul_epc: got %h expected %h", epc, e); end
        e = exp_q.pop_front(); n_checks++;
        if (cause !== e) begin n_fail++; $display("FAIL simul_cause: got %h expected %h", cause, e); end
        eret = 1'b1; step(1); eret = 1'b0;
    endtask

    task test_count_wrap;
        exp_q.push_back(32'hFFFF_FFFF); exp_q.push_back(32'h0);
        mtc0(5'd9, 3'd0, 32'hFFFF_FFFF);
        read_reg(5'd9, 3'd0, v);
        e = exp_q.pop_front(); n_checks++;
        if (v !== e) begin n_fail++; $display("FAIL count_load: got %h expected %h", v, e); end
        step(DIV);
        read_reg(5'd9, 3'd0, v);
        e = exp_q.pop_front(); n_checks++;
        if (v !== e) begin n_fail++; $display("FAIL count_wrap: got %h expected %h", v, e); end
    endtask

    task test_hw_int;
        mtc0(5'd12, 3'd0, 32'h0000_1001);
        exp_q.push_back(32'h0); exp_q.push_back(32'h1); exp_q.push_back(32'h0000_1034); exp_q.push_back(32'h0);
        hardware_int = 6'b000100;
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (32'(int_req) !== e) begin n_fail++; $display("FAIL hw_same_cycle: got %h expected %h", int_req, e); end
        step(1);
        e = exp_q.pop_front(); n_checks++;
        if (32'(int_req) !== e) begin n_fail++; $display("FAIL hw_int_req: got %h expected %h", int_req, e); end
        e = exp_q.pop_front(); n_checks++;
        if (cause !== e) begin n_fail++; $display("FAIL hw_cause: got %h expected %h", cause, e); end
        hardware_int = 6'b0;
        step(1);
        e = exp_q.pop_front(); n_checks++;
        if (32'(int_req) !== e) begin n_fail++; $display("FAIL hw_release: got %h expected %h", int_req, e); end
    endtask

    initial begin
        rst = 1'b1; reg_we = 1'b0; reg_write_addr = '0; reg_write_sel = '0; reg_write = '0;
        reg_read_addr = '0; reg_read_sel = '0; hardware_int = '0; stall = 1'b0;
        exc_valid = 1'b0; exc_code = '0; exc_pc = '0; exc_bd = 1'b0; eret = 1'b0;
        step(1);
        test_reset;
        test_timer;
        test_clear_wins;
        test_exception;
        test_simultaneous;
        test_count_wrap;
        test_hw_int;
        test_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
